// File: rtl/swlogic_pkg.sv
// Shared definitions for the switch logic array: op encoding and the
// reduction helper used by every channel.
package swlogic_pkg;

    localparam int OP_W     = 2;
    localparam int MAX_SW_W = 32;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_XNOR = 2'd3
    } swOp_t;

    // Reduces the low 'width' bits of 'bits' with the selected op.
    // Bits above 'width' are ignored.
    function automatic logic reduce_op(input logic [MAX_SW_W-1:0] bits,
                                       input swOp_t op,
                                       input int unsigned width = MAX_SW_W);
        logic andR;
        logic orR;
        logic xorR;
        andR = 1'b1;
        orR  = 1'b0;
        xorR = 1'b0;
        for (int unsigned i = 0; i < MAX_SW_W; i++) begin
            if (i < width) begin
                andR = andR & bits[i];
                orR  = orR | bits[i];
                xorR = xorR ^ bits[i];
            end
        end
        case (op)
            OP_AND:  reduce_op = andR;
            OP_OR:   reduce_op = orR;
            OP_XOR:  reduce_op = xorR;
            default: reduce_op = ~xorR;
        endcase
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch bit: two-flop synchroniser followed by a debouncer that only
// accepts a new level after it has differed from the accepted level for
// DEBOUNCE_CYCLES consecutive cycles.
module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic swRaw,
    output logic swStable
);

    localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    // Synchronise the raw pin, then count consecutive disagreeing cycles;
    // any cycle of agreement restarts the count so glitches are dropped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            swStable <= 1'b0;
            cnt      <= '0;
        end else begin
            s1 <= swRaw;
            s2 <= s1;
            if (s2 == swStable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                swStable <= s2;
                cnt      <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_logic_array.sv
// NUM_CH independent channels, each reducing SW_W debounced switch bits with
// a run-time selected op onto one registered LED.
// Optional feature: define SWLOGIC_TOGGLE_EN to make each LED a toggle flop
// that inverts on every rising edge of its channel's op result.
module switch_logic_array
    import swlogic_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int SW_W            = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_CH*SW_W-1:0] io_sw,
    input  logic [NUM_CH*OP_W-1:0] io_op,
    output logic [NUM_CH-1:0]      io_led,
    output logic [NUM_CH-1:0]      io_changed
);

    logic [NUM_CH*SW_W-1:0] stableBits;
    logic [NUM_CH-1:0]      opResult;
    logic [NUM_CH-1:0]      ledNext;
    logic                   armed;

    genvar g;
    generate
        for (g = 0; g < NUM_CH * SW_W; g++) begin : g_deb
            sw_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clock   (clock),
                .reset   (reset),
                .swRaw   (io_sw[g]),
                .swStable(stableBits[g])
            );
        end
    endgenerate

    // Per-channel reduction of the accepted switch levels.
    always_comb begin
        opResult = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            opResult[c] = reduce_op(MAX_SW_W'(stableBits[c*SW_W +: SW_W]),
                                    swOp_t'(io_op[c*OP_W +: OP_W]),
                                    SW_W);
        end
    end

`ifdef SWLOGIC_TOGGLE_EN
    logic [NUM_CH-1:0] resultQ;

    // Toggle on each 0->1 transition of the op result.
    always_comb begin
        ledNext = io_led ^ (opResult & ~resultQ);
    end

    // Previous op result, used for rising-edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            resultQ <= '0;
        end else if (armed) begin
            resultQ <= opResult;
        end
    end
`else
    // LED follows the op result directly.
    always_comb begin
        ledNext = opResult;
    end
`endif

    // LED and change-pulse registers; the first cycle after reset only arms
    // the block so io_changed can never fire on that cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            armed      <= 1'b0;
            io_led     <= '0;
            io_changed <= '0;
        end else if (!armed) begin
            armed      <= 1'b1;
            io_changed <= '0;
        end else begin
            io_led     <= ledNext;
            io_changed <= ledNext ^ io_led;
        end
    end

endmodule

// File: tb/tb_switch_logic_array.sv
// Directed bench for switch_logic_array with NUM_CH=4, SW_W=2, DEBOUNCE_CYCLES=4.
module tb_switch_logic_array;

    logic       clock;
    logic       reset;
    logic [7:0] io_sw;
    logic [7:0] io_op;
    logic [3:0] io_led;
    logic [3:0] io_changed;

    int checks   = 0;
    int failures = 0;
    int chgCount;

    switch_logic_array #(
        .NUM_CH(4),
        .SW_W(2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .io_sw     (io_sw),
        .io_op     (io_op),
        .io_led    (io_led),
        .io_changed(io_changed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b0;
        step(2);
        reset = 1'b1;
        step(3);
    endtask

    logic [3:0] expLed5 [8];
    logic [3:0] expChg5 [8];
    logic       expT4   [3];
    logic       expT6   [3];

    initial begin
        reset = 1'b0;
        io_sw = '0;
        io_op = '0;
        step(3);
        reset = 1'b1;
        step(3);
        checkValue("reset_led", io_led, 4'h0);
        checkValue("reset_chg", io_changed, 4'h0);

        // 1: reset mid-run with all switches high
        io_op = 8'b01_01_01_01;
        io_sw = 8'hFF;
        step(12);
        checkValue("t1_run_led", io_led, 4'hF);
        #3 reset = 1'b0;
        #1;
        checkValue("t1_async_led", io_led, 4'h0);
        checkValue("t1_async_chg", io_changed, 4'h0);
        step(3);
        checkValue("t1_hold_led", io_led, 4'h0);
        checkValue("t1_hold_chg", io_changed, 4'h0);
        io_sw = 8'h00;
        io_op = 8'h00;
        reset = 1'b1;
        step(12);
        checkValue("t1_after_led", io_led, 4'h0);

        // 2: ch0 AND, 00 -> 11, led rises 7 edges after sampling edge
        io_sw = 8'h03;
        step(6);
        checkValue("t2_edge6_led", io_led, 4'h0);
        step(1);
        checkValue("t2_edge7_led", io_led, 4'h1);
        checkValue("t2_edge7_chg", io_changed, 4'h1);
        step(1);
        checkValue("t2_edge8_led", io_led, 4'h1);
        checkValue("t2_edge8_chg", io_changed, 4'h0);

        // 3: ch1 XOR, 3-cycle glitch rejected, 4-cycle pulse accepted
        doReset();
        io_op = 8'b00_00_10_00;
        chgCount = 0;
        io_sw[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            if (io_changed[1]) chgCount++;
        end
        io_sw[2] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (io_changed[1]) chgCount++;
        end
        checkValue("t3_glitch_led", io_led[1], 1'b0);
        checkValue("t3_glitch_chg", chgCount, 0);
        io_sw[2] = 1'b1;
        step(4);
        io_sw[2] = 1'b0;
        step(4);
        checkValue("t3_pulse4_led", io_led[1], 1'b1);
        step(6);
`ifdef SWLOGIC_TOGGLE_EN
        checkValue("t3_pulse4_after", io_led[1], 1'b1);
`else
        checkValue("t3_pulse4_after", io_led[1], 1'b0);
`endif

        // 4: ch2 stable 10, step through ops
        doReset();
        io_sw = 8'b00_10_00_00;
        step(10);
        checkValue("t4_and_led", io_led[2], 1'b0);
`ifdef SWLOGIC_TOGGLE_EN
        expT4 = '{1'b1, 1'b1, 1'b1};
`else
        expT4 = '{1'b1, 1'b1, 1'b0};
`endif
        for (int op = 1; op < 4; op++) begin
            io_op[5:4] = 2'(op);
            checkValue($sformatf("t4_op%0d_before", op), io_led[2], (op == 1) ? 1'b0 : expT4[op-2]);
            step(1);
            checkValue($sformatf("t4_op%0d_led", op), io_led[2], expT4[op-1]);
        end

        // 5: all channels at once, checked every cycle
        reset = 1'b0;
        step(1);
        io_op = 8'b11_10_01_00;
        io_sw = 8'b00_11_01_11;
        expLed5 = '{4'h0, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'hB, 4'hB};
        expChg5 = '{4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h3, 4'h0};
        reset = 1'b1;
        for (int e = 0; e < 8; e++) begin
            step(1);
            checkValue($sformatf("t5_e%0d_led", e + 1), io_led, expLed5[e]);
            checkValue($sformatf("t5_e%0d_chg", e + 1), io_changed, expChg5[e]);
        end

        // 6: ch3 OR, three debounced pulses
        io_sw = 8'h00;
        io_op = 8'b01_00_00_00;
        doReset();
        step(4);
`ifdef SWLOGIC_TOGGLE_EN
        expT6 = '{1'b1, 1'b0, 1'b1};
`else
        expT6 = '{1'b1, 1'b1, 1'b1};
`endif
        chgCount = 0;
        for (int p = 0; p < 3; p++) begin
            io_sw[6] = 1'b1;
            for (int i = 0; i < 10; i++) begin
                step(1);
                if (io_changed[3]) chgCount++;
            end
            checkValue($sformatf("t6_p%0d_high", p), io_led[3], expT6[p]);
            io_sw[6] = 1'b0;
            for (int i = 0; i < 10; i++) begin
                step(1);
                if (io_changed[3]) chgCount++;
            end
`ifdef SWLOGIC_TOGGLE_EN
            checkValue($sformatf("t6_p%0d_low", p), io_led[3], expT6[p]);
`else
            checkValue($sformatf("t6_p%0d_low", p), io_led[3], 1'b0);
`endif
        end
`ifdef SWLOGIC_TOGGLE_EN
        checkValue("t6_chg_count", chgCount, 3);
`else
        checkValue("t6_chg_count", chgCount, 6);
`endif
        checkValue("t6_other_led", io_led[2:0], 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
